lieat_exu_alu_dpath: RTL and testbench

Execution-side ALU responder in the EXU: consumes the operand pair and one-hot operation selects produced by the ALU request front-end and returns a registered result with a valid/ready handshake toward writeback. Add/sub/logic/compare/LUI complete in one cycle. Shifts run as a two-phase split shifter, so the block contains a small FSM and an output holding register with backpressure. A flush input discards in-flight work on redirect.

---
 rtl/lieat_exu_alu_dpath_if.sv | 45 ++++
 rtl/lieat_exu_alu_dpath.sv | 162 ++++++++++++++++
 tb/tb_lieat_exu_alu_dpath.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lieat_exu_alu_dpath_if.sv
// Request/response bundle between the ALU request front-end, the EXU ALU
// datapath and writeback. The master side issues requests and consumes
// results; the slave side is the ALU datapath itself.
interface lieat_exu_alu_dpath_if #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
);
  logic            alu_req_valid;
  logic            alu_req_ready;
  logic [XLEN-1:0] alu_req_op1;
  logic [XLEN-1:0] alu_req_op2;
  logic            alu_req_add;
  logic            alu_req_sub;
  logic            alu_req_xor;
  logic            alu_req_sll;
  logic            alu_req_srl;
  logic            alu_req_sra;
  logic            alu_req_or;
  logic            alu_req_and;
  logic            alu_req_slt;
  logic            alu_req_sltu;
  logic            alu_req_lui;
  logic [TAGW-1:0] alu_req_tag;
  logic            alu_rsp_valid;
  logic            alu_rsp_ready;
  logic [XLEN-1:0] alu_rsp_data;
  logic [TAGW-1:0] alu_rsp_tag;
  logic            alu_rsp_err;

  modport master (
    output alu_req_valid, alu_req_op1, alu_req_op2,
           alu_req_add, alu_req_sub, alu_req_xor, alu_req_sll, alu_req_srl,
           alu_req_sra, alu_req_or, alu_req_and, alu_req_slt, alu_req_sltu,
           alu_req_lui, alu_req_tag, alu_rsp_ready,
    input  alu_req_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_tag, alu_rsp_err
  );

  modport slave (
    input  alu_req_valid, alu_req_op1, alu_req_op2,
           alu_req_add, alu_req_sub, alu_req_xor, alu_req_sll, alu_req_srl,
           alu_req_sra, alu_req_or, alu_req_and, alu_req_slt, alu_req_sltu,
           alu_req_lui, alu_req_tag, alu_rsp_ready,
    output alu_req_ready, alu_rsp_valid, alu_rsp_data, alu_rsp_tag, alu_rsp_err
  );
endinterface

// File: rtl/lieat_exu_alu_dpath.sv
// EXU ALU datapath: single-cycle add/sub/logic/compare/lui, two-phase split
// shifter (fine shift by amt[2:0], then coarse shift by the byte-multiple
// part), registered result with valid/ready backpressure and flush support.
module lieat_exu_alu_dpath #(
  parameter int XLEN = 32,
  parameter int TAGW = 5
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  lieat_exu_alu_dpath_if.slave alu
);
  localparam int SHW = $clog2(XLEN);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    KIND_SLL = 2'd0,
    KIND_SRL = 2'd1,
    KIND_SRA = 2'd2
  } shift_kind_t;

  state_t          state;
  state_t          state_nxt;

  logic [10:0]     sel;
  logic            err_op;
  logic            shift_op;
  logic            accept;
  logic [SHW-1:0]  amt;
  logic [2:0]      amt_lo;
  logic [SHW-1:0]  amt_hi;
  logic [XLEN-1:0] fine_data;
  logic [XLEN-1:0] fast_data;
  logic [XLEN-1:0] coarse_data;

  logic [XLEN-1:0] sh_partial;
  logic [SHW-1:0]  sh_amt;
  shift_kind_t     sh_kind;
  logic [TAGW-1:0] sh_tag;

  logic            rsp_valid;
  logic [XLEN-1:0] rsp_data;
  logic [TAGW-1:0] rsp_tag;
  logic            rsp_err;

  assign sel = {alu.alu_req_lui, alu.alu_req_sltu, alu.alu_req_slt,
                alu.alu_req_and, alu.alu_req_or, alu.alu_req_sra,
                alu.alu_req_srl, alu.alu_req_sll, alu.alu_req_xor,
                alu.alu_req_sub, alu.alu_req_add};

  assign err_op   = ($countones(sel) != 1);
  assign shift_op = ~err_op & (alu.alu_req_sll | alu.alu_req_srl | alu.alu_req_sra);

  assign amt    = alu.alu_req_op2[SHW-1:0];
  assign amt_lo = amt[2:0];
  assign amt_hi = {amt[SHW-1:3], 3'b000};

  assign alu.alu_req_ready = (state == IDLE) & ~flush & (~rsp_valid | alu.alu_rsp_ready);
  assign accept            = alu.alu_req_valid & alu.alu_req_ready;

  assign alu.alu_rsp_valid = rsp_valid;
  assign alu.alu_rsp_data  = rsp_data;
  assign alu.alu_rsp_tag   = rsp_tag;
  assign alu.alu_rsp_err   = rsp_err;

  // Single-cycle result; malformed selects force zero data
  always_comb begin
    fast_data = '0;
    if (!err_op) begin
      if (alu.alu_req_add)  fast_data = alu.alu_req_op1 + alu.alu_req_op2;
      if (alu.alu_req_sub)  fast_data = alu.alu_req_op1 - alu.alu_req_op2;
      if (alu.alu_req_xor)  fast_data = alu.alu_req_op1 ^ alu.alu_req_op2;
      if (alu.alu_req_or)   fast_data = alu.alu_req_op1 | alu.alu_req_op2;
      if (alu.alu_req_and)  fast_data = alu.alu_req_op1 & alu.alu_req_op2;
      if (alu.alu_req_slt)  fast_data = {{(XLEN-1){1'b0}},
                                         ($signed(alu.alu_req_op1) < $signed(alu.alu_req_op2))};
      if (alu.alu_req_sltu) fast_data = {{(XLEN-1){1'b0}}, (alu.alu_req_op1 < alu.alu_req_op2)};
      if (alu.alu_req_lui)  fast_data = alu.alu_req_op2;
    end
  end

  // Phase 1: fine shift of op1 by the low three amount bits
  always_comb begin
    fine_data = alu.alu_req_op1 << amt_lo;
    if (alu.alu_req_srl) fine_data = alu.alu_req_op1 >> amt_lo;
    if (alu.alu_req_sra) fine_data = $signed(alu.alu_req_op1) >>> amt_lo;
  end

  // Phase 2: coarse shift of the latched partial; its MSB still carries op1's sign
  always_comb begin
    case (sh_kind)
      KIND_SRL: coarse_data = sh_partial >> sh_amt;
      KIND_SRA: coarse_data = $signed(sh_partial) >>> sh_amt;
      default:  coarse_data = sh_partial << sh_amt;
    endcase
  end

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state: a shift takes exactly one extra cycle, flush always returns to idle
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && shift_op) state_nxt = SHIFT;
        SHIFT:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Latch the phase-1 partial, shift kind, coarse amount and tag on shift accept
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sh_partial <= '0;
      sh_amt     <= '0;
      sh_kind    <= KIND_SLL;
      sh_tag     <= '0;
    end else if (accept && shift_op) begin
      sh_partial <= fine_data;
      sh_amt     <= amt_hi;
      sh_tag     <= alu.alu_req_tag;
      if (alu.alu_req_sra)      sh_kind <= KIND_SRA;
      else if (alu.alu_req_srl) sh_kind <= KIND_SRL;
      else                      sh_kind <= KIND_SLL;
    end
  end

  // Output holding register: flush drops, shift completion or single-cycle accept loads, drain clears
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_tag   <= '0;
      rsp_err   <= 1'b0;
    end else if (flush) begin
      rsp_valid <= 1'b0;
    end else if (state == SHIFT) begin
      rsp_valid <= 1'b1;
      rsp_data  <= coarse_data;
      rsp_tag   <= sh_tag;
      rsp_err   <= 1'b0;
    end else if (accept && !shift_op) begin
      rsp_valid <= 1'b1;
      rsp_data  <= fast_data;
      rsp_tag   <= alu.alu_req_tag;
      rsp_err   <= err_op;
    end else if (alu.alu_rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_lieat_exu_alu_dpath.sv
// Self-checking bench for lieat_exu_alu_dpath: directed cases with literal
// expectations followed by randomized traffic checked every cycle against a
// transaction-level model of the responder.
module tb_lieat_exu_alu_dpath;
  localparam int XLEN = 32;
  localparam int TAGW = 5;

  localparam int OP_ADD  = 0;
  localparam int OP_SUB  = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_SLL  = 3;
  localparam int OP_SRL  = 4;
  localparam int OP_SRA  = 5;
  localparam int OP_OR   = 6;
  localparam int OP_AND  = 7;
  localparam int OP_SLT  = 8;
  localparam int OP_SLTU = 9;
  localparam int OP_LUI  = 10;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [10:0] req_sel = '0;

  int n_checks = 0;
  int n_pass   = 0;

  lieat_exu_alu_dpath_if #(.XLEN(XLEN), .TAGW(TAGW)) bus ();

  lieat_exu_alu_dpath #(.XLEN(XLEN), .TAGW(TAGW)) dut (
    .clock(clock),
    .reset(reset),
    .flush(flush),
    .alu  (bus.slave)
  );

  assign bus.alu_req_add  = req_sel[OP_ADD];
  assign bus.alu_req_sub  = req_sel[OP_SUB];
  assign bus.alu_req_xor  = req_sel[OP_XOR];
  assign bus.alu_req_sll  = req_sel[OP_SLL];
  assign bus.alu_req_srl  = req_sel[OP_SRL];
  assign bus.alu_req_sra  = req_sel[OP_SRA];
  assign bus.alu_req_or   = req_sel[OP_OR];
  assign bus.alu_req_and  = req_sel[OP_AND];
  assign bus.alu_req_slt  = req_sel[OP_SLT];
  assign bus.alu_req_sltu = req_sel[OP_SLTU];
  assign bus.alu_req_lui  = req_sel[OP_LUI];

  // Free-running clock
  always #5 clock = ~clock;

  // Reference: what a request must produce, straight from the operation rules
  function automatic void refOp(input logic [10:0] s, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic e, output logic sh);
    r  = '0;
    sh = 1'b0;
    e  = ($countones(s) != 1);
    if (!e) begin
      if (s[OP_ADD])  r = a + b;
      if (s[OP_SUB])  r = a - b;
      if (s[OP_XOR])  r = a ^ b;
      if (s[OP_OR])   r = a | b;
      if (s[OP_AND])  r = a & b;
      if (s[OP_SLT])  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (s[OP_SLTU]) r = (a < b) ? 32'd1 : 32'd0;
      if (s[OP_LUI])  r = b;
      if (s[OP_SLL]) begin r = a << b[4:0]; sh = 1'b1; end
      if (s[OP_SRL]) begin r = a >> b[4:0]; sh = 1'b1; end
      if (s[OP_SRA]) begin r = $signed(a) >>> b[4:0]; sh = 1'b1; end
    end
  endfunction

  // Model state: the pending response and a shift result still in flight
  logic        m_valid = 1'b0;
  logic [31:0] m_data  = '0;
  logic [4:0]  m_tag   = '0;
  logic        m_err   = 1'b0;
  logic        m_busy  = 1'b0;
  logic [31:0] m_sh_data = '0;
  logic [4:0]  m_sh_tag  = '0;

  function automatic logic modelReady();
    return !m_busy && !flush && (!m_valid || bus.alu_rsp_ready);
  endfunction

  // Advance the model at each edge using the inputs that were presented before it
  always @(posedge clock or posedge reset) begin
    logic        acc, drain, e, sh;
    logic [31:0] r;
    if (reset) begin
      m_valid = 1'b0; m_data = '0; m_tag = '0; m_err = 1'b0; m_busy = 1'b0;
    end else begin
      acc   = bus.alu_req_valid && modelReady();
      drain = m_valid && bus.alu_rsp_ready;
      if (flush) begin
        m_valid = 1'b0;
        m_busy  = 1'b0;
      end else if (m_busy) begin
        m_valid = 1'b1; m_data = m_sh_data; m_tag = m_sh_tag; m_err = 1'b0;
        m_busy  = 1'b0;
      end else if (acc) begin
        refOp(req_sel, bus.alu_req_op1, bus.alu_req_op2, r, e, sh);
        if (sh) begin
          m_busy = 1'b1; m_sh_data = r; m_sh_tag = bus.alu_req_tag;
          if (drain) m_valid = 1'b0;
        end else begin
          m_valid = 1'b1; m_data = r; m_tag = bus.alu_req_tag; m_err = e;
        end
      end else if (drain) begin
        m_valid = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
  endtask

  // Every cycle out of reset, compare the DUT against the model
  always @(negedge clock) begin
    if (!reset) begin
      checkOutput("req_ready", {31'd0, bus.alu_req_ready}, {31'd0, modelReady()});
      checkOutput("rsp_valid", {31'd0, bus.alu_rsp_valid}, {31'd0, m_valid});
      if (m_valid) begin
        checkOutput("rsp_data", bus.alu_rsp_data, m_data);
        checkOutput("rsp_tag", {27'd0, bus.alu_rsp_tag}, {27'd0, m_tag});
        checkOutput("rsp_err", {31'd0, bus.alu_rsp_err}, {31'd0, m_err});
      end
    end
  end

  task automatic syncDrive();
    @(posedge clock);
    #2;
  endtask

  task automatic applyStimulus(input logic [10:0] s, input logic [31:0] a, input logic [31:0] b,
                               input logic [4:0] t);
    req_sel           = s;
    bus.alu_req_op1   = a;
    bus.alu_req_op2   = b;
    bus.alu_req_tag   = t;
    bus.alu_req_valid = 1'b1;
  endtask

  task automatic idleReq();
    bus.alu_req_valid = 1'b0;
  endtask

  // Wait until the presented request is taken; returns just after the accepting edge
  task automatic waitAccept(input string name);
    bit got = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      if (bus.alu_req_ready) begin got = 1; break; end
    end
    if (!got) checkOutput({name, "_accept_timeout"}, 32'd0, 32'd1);
    @(posedge clock);
    #2;
  endtask

  function automatic logic [31:0] pickOperand();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.alu_req_valid = 1'b0;
    bus.alu_req_op1   = '0;
    bus.alu_req_op2   = '0;
    bus.alu_req_tag   = '0;
    bus.alu_rsp_ready = 1'b1;

    // Reset values
    repeat (2) @(posedge clock);
    #2;
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_valid", {31'd0, bus.alu_rsp_valid}, 32'd0);
    checkOutput("rst_data", bus.alu_rsp_data, 32'd0);
    checkOutput("rst_tag", {27'd0, bus.alu_rsp_tag}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.alu_rsp_err}, 32'd0);
    checkOutput("rst_ready", {31'd0, bus.alu_req_ready}, 32'd1);

    // add 5 + (-3)
    syncDrive();
    applyStimulus(11'(1 << OP_ADD), 32'h0000_0005, 32'hFFFF_FFFD, 5'd3);
    waitAccept("add");
    idleReq();
    @(negedge clock);
    checkOutput("add_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("add_data", bus.alu_rsp_data, 32'h0000_0002);
    checkOutput("add_tag", {27'd0, bus.alu_rsp_tag}, 32'd3);
    checkOutput("add_err", {31'd0, bus.alu_rsp_err}, 32'd0);

    // slt then sltu back to back
    syncDrive();
    applyStimulus(11'(1 << OP_SLT), 32'hFFFF_FFFF, 32'h0000_0001, 5'd4);
    waitAccept("slt");
    applyStimulus(11'(1 << OP_SLTU), 32'hFFFF_FFFF, 32'h0000_0001, 5'd5);
    @(negedge clock);
    checkOutput("slt_data", bus.alu_rsp_data, 32'd1);
    checkOutput("slt_tag", {27'd0, bus.alu_rsp_tag}, 32'd4);
    checkOutput("sltu_ready", {31'd0, bus.alu_req_ready}, 32'd1);
    syncDrive();
    idleReq();
    @(negedge clock);
    checkOutput("sltu_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("sltu_data", bus.alu_rsp_data, 32'd0);
    checkOutput("sltu_tag", {27'd0, bus.alu_rsp_tag}, 32'd5);

    // sra by 31, then srl by 31
    syncDrive();
    applyStimulus(11'(1 << OP_SRA), 32'h8000_0000, 32'h0000_003F, 5'd6);
    waitAccept("sra");
    idleReq();
    @(negedge clock);
    checkOutput("sra_busy_ready", {31'd0, bus.alu_req_ready}, 32'd0);
    checkOutput("sra_busy_valid", {31'd0, bus.alu_rsp_valid}, 32'd0);
    @(negedge clock);
    checkOutput("sra_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("sra_data", bus.alu_rsp_data, 32'hFFFF_FFFF);
    checkOutput("sra_tag", {27'd0, bus.alu_rsp_tag}, 32'd6);
    syncDrive();
    applyStimulus(11'(1 << OP_SRL), 32'h8000_0000, 32'h0000_003F, 5'd7);
    waitAccept("srl");
    idleReq();
    @(negedge clock);
    @(negedge clock);
    checkOutput("srl_data", bus.alu_rsp_data, 32'h0000_0001);

    // Backpressure with a new request waiting, then drain and accept in one edge
    syncDrive();
    bus.alu_rsp_ready = 1'b0;
    applyStimulus(11'(1 << OP_ADD), 32'd10, 32'd20, 5'd8);
    waitAccept("bp_add");
    applyStimulus(11'(1 << OP_XOR), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 5'd9);
    repeat (3) begin
      @(negedge clock);
      checkOutput("bp_ready", {31'd0, bus.alu_req_ready}, 32'd0);
      checkOutput("bp_data", bus.alu_rsp_data, 32'd30);
      checkOutput("bp_tag", {27'd0, bus.alu_rsp_tag}, 32'd8);
    end
    #2;
    bus.alu_rsp_ready = 1'b1;
    #1;
    checkOutput("bp_release_ready", {31'd0, bus.alu_req_ready}, 32'd1);
    syncDrive();
    idleReq();
    @(negedge clock);
    checkOutput("bp_xor_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("bp_xor_data", bus.alu_rsp_data, 32'hFF00_FF00);
    checkOutput("bp_xor_tag", {27'd0, bus.alu_rsp_tag}, 32'd9);

    // Flush during the SHIFT cycle of an sll
    syncDrive();
    applyStimulus(11'(1 << OP_SLL), 32'd1, 32'd4, 5'd10);
    waitAccept("sll_flush");
    idleReq();
    flush = 1'b1;
    @(negedge clock);
    checkOutput("flush_ready", {31'd0, bus.alu_req_ready}, 32'd0);
    syncDrive();
    flush = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("flush_no_rsp", {31'd0, bus.alu_rsp_valid}, 32'd0);
      checkOutput("flush_ready_after", {31'd0, bus.alu_req_ready}, 32'd1);
    end

    // Malformed selects: two set, then none
    syncDrive();
    applyStimulus(11'((1 << OP_ADD) | (1 << OP_OR)), 32'd1, 32'd2, 5'd11);
    waitAccept("err_two");
    idleReq();
    @(negedge clock);
    checkOutput("err_two_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("err_two_data", bus.alu_rsp_data, 32'd0);
    checkOutput("err_two_err", {31'd0, bus.alu_rsp_err}, 32'd1);
    syncDrive();
    applyStimulus(11'd0, 32'd1, 32'd2, 5'd12);
    waitAccept("err_none");
    idleReq();
    @(negedge clock);
    checkOutput("err_none_valid", {31'd0, bus.alu_rsp_valid}, 32'd1);
    checkOutput("err_none_data", bus.alu_rsp_data, 32'd0);
    checkOutput("err_none_err", {31'd0, bus.alu_rsp_err}, 32'd1);
    checkOutput("err_none_tag", {27'd0, bus.alu_rsp_tag}, 32'd12);

    // Reset in the middle of a shift
    syncDrive();
    applyStimulus(11'(1 << OP_SRA), 32'hDEAD_BEEF, 32'd13, 5'd14);
    waitAccept("rst_shift");
    idleReq();
    reset = 1'b1;
    #1;
    checkOutput("rst_mid_valid", {31'd0, bus.alu_rsp_valid}, 32'd0);
    checkOutput("rst_mid_tag", {27'd0, bus.alu_rsp_tag}, 32'd0);
    checkOutput("rst_mid_err", {31'd0, bus.alu_rsp_err}, 32'd0);
    syncDrive();
    reset = 1'b0;
    repeat (2) begin
      @(negedge clock);
      checkOutput("rst_mid_no_rsp", {31'd0, bus.alu_rsp_valid}, 32'd0);
    end

    // Randomized traffic, checked every cycle by the model comparison
    for (int i = 0; i < 800; i++) begin
      int          pick;
      logic [10:0] s;
      syncDrive();
      pick = $urandom_range(0, 19);
      if (pick < 11)      s = 11'(1 << pick);
      else if (pick < 14) s = 11'($urandom);
      else                s = 11'(1 << $urandom_range(OP_SLL, OP_SRA));
      req_sel           = s;
      bus.alu_req_op1   = pickOperand();
      bus.alu_req_op2   = pickOperand();
      bus.alu_req_tag   = 5'($urandom);
      bus.alu_req_valid = ($urandom_range(0, 3) != 0);
      bus.alu_rsp_ready = ($urandom_range(0, 9) < 7);
      flush             = ($urandom_range(0, 19) == 0);
    end

    syncDrive();
    idleReq();
    flush = 1'b0;
    bus.alu_rsp_ready = 1'b1;
    repeat (4) @(negedge clock);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
